cfg_axis_unpack: RTL
====================

// Module: cfg_axis_unpack
// PURPOSE
//  Upstream feeder of the configuration register stage. Receives packed layer-config records over the
//  AXIS_BW-wide host/DMA stream and repacks them into one CFG_BW-bit word per beat on s_axis_cfg_* of
//  the CFG stage. Records are packed back-to-back, LSB-first, and may straddle input beats.
//  Frame boundaries (tlast) are carried through. Residue bits at frame end are padding and are discarded.
// PARAMETERS
//  AXIS_BW   256  input stream width; must be > CFG_BW
//  CFG_BW    96   config word width; must match the CFG stage
//  STAT_BW   16   width of the saturating statistics counters
//  BUF_W     AXIS_BW+CFG_BW (localparam)  holding-buffer width; 352 at defaults
//  CNT_BW    $clog2(BUF_W+1) (localparam) width of the valid-bit count
// PORTS
//  clk            in   1        clock
//  rstn           in   1        synchronous reset, active-low
//  s_axis_tvalid  in   1        input beat valid
//  s_axis_tready  out  1        input beat accepted when tvalid&&tready
//  s_axis_tdata   in   AXIS_BW  packed config bits; bit 0 is the earliest bit
//  s_axis_tlast   in   1        last beat of a config frame
//  m_axis_tvalid  out  1        config word valid; connects to s_axis_cfg_tvalid of CFG
//  m_axis_tready  in   1        connects to s_axis_cfg_tready of CFG
//  m_axis_tdata   out  CFG_BW   config word; connects to s_axis_cfg_tdata
//  m_axis_tlast   out  1        last word of the frame
//  stat_words     out  STAT_BW  words emitted since reset; saturates
//  stat_frames    out  STAT_BW  frames completed since reset; saturates
//  residue_bits   out  CNT_BW   bits discarded at the most recent frame end
// BEHAVIOUR
//  State: buf[BUF_W], cnt (valid bits, LSB-aligned in buf), last_pend (tlast beat absorbed).
//  Reset: buf=0, cnt=0, last_pend=0, stat_words=0, stat_frames=0, residue_bits=0;
//   outputs after reset: s_axis_tready=1, m_axis_tvalid=0, m_axis_tlast=0.
//  s_axis_tready = (cnt < CFG_BW) && !last_pend   (combinational from registers only)
//  m_axis_tvalid = (cnt >= CFG_BW)                (push and pop are mutually exclusive)
//  m_axis_tdata  = buf[CFG_BW-1:0]
//   - held stable while tvalid && !tready; no combinational path from m_axis_tready to any output.
//  m_axis_tlast = last_pend && (cnt < 2*CFG_BW)
//  Push (s hs): buf[cnt +: AXIS_BW] <= tdata; cnt <= cnt+AXIS_BW; last_pend <= tlast.
//  Pop (m hs), not last: buf <= buf >> CFG_BW; cnt <= cnt-CFG_BW; stat_words++.
//  Pop with m_axis_tlast=1 (flush):
//   - residue_bits <= cnt-CFG_BW; buf <= 0; cnt <= 0; last_pend <= 0
//   - stat_words++, stat_frames++.
//  Latency: first word valid the cycle after the push that makes cnt >= CFG_BW; back-to-back pops 1/cycle.
//  Throughput: one input beat per floor((cnt+AXIS_BW)/CFG_BW) output words; acceptable for config traffic.
//  Boundaries:
//   - Beat with tlast and cnt+AXIS_BW < CFG_BW cannot occur, since AXIS_BW > CFG_BW.
//   - Every frame therefore yields >= 1 word.
//   - Exact fit (cnt == CFG_BW at frame end): residue_bits=0.
//   - The word after a flush starts from bit 0 of the next frame's first beat; frames never share a word.
//   - Counters saturate at all-ones and do not wrap.
//   - rstn low mid-frame: all buffered bits are dropped. No tlast is emitted for the aborted frame.
//     The next frame starts clean.
// STRUCTURE
//  definesPkg: add localparam CFG_BW=96 and AXIS_BW=256 defaults.
//   - Share these with the CFG stage so the two widths cannot diverge.
//  Single module, no sub-modules. Use the variable part-select write and a fixed right shift.
//  Add an elaboration-time assertion: AXIS_BW > CFG_BW.
// TESTING
//  1. One beat, tlast=1, data=256'hAAAA..., m_tready=1:
//     -> 2 words: bits[95:0], then bits[191:96] with tlast; residue_bits=64; stat_frames=1.
//  2. Three beats, last one tlast, 768 bits:
//     -> exactly 8 words, word k = stream[96k+:96], only word 7 has tlast; residue_bits=0.
//  3. Straddle: beat0 then beat1, no tlast between them:
//     -> word 2 = {beat1[31:0], beat0[255:192]}.
//  4. m_tready held 0 for 10 cycles with m_tvalid=1:
//     -> m_tdata/tlast stable, s_tready=0 for all 10 cycles, no data lost.
//  5. rstn low for 1 cycle after the first pop of a 2-beat frame:
//     -> m_tvalid=0 and s_tready=1 next cycle; a following 1-beat frame yields 2 words with correct data.
//  6. Connected to the CFG stage, cfg_finish low for 5 cycles:
//     -> backpressure reaches s_tready; each word produces exactly one cfg_start pulse.

Source files
------------

// File: rtl/cfg_axis_unpack_pkg.sv
// Shared width defaults for the config-stream unpacker and the CFG register stage,
// kept in one place so the producer and consumer word widths cannot drift apart.
package cfg_axis_unpack_pkg;

  localparam int AXIS_BW = 256;
  localparam int CFG_BW  = 96;
  localparam int STAT_BW = 16;

endpackage

// File: rtl/cfg_axis_unpack.sv
// Repacks back-to-back, LSB-first config records from a wide AXI-Stream into one
// CFG_BW-bit word per output beat, carrying frame boundaries and dropping end-of-frame padding.
module cfg_axis_unpack #(
  parameter int AXIS_BW = cfg_axis_unpack_pkg::AXIS_BW,
  parameter int CFG_BW  = cfg_axis_unpack_pkg::CFG_BW,
  parameter int STAT_BW = cfg_axis_unpack_pkg::STAT_BW,
  localparam int BUF_W  = AXIS_BW + CFG_BW,
  localparam int CNT_BW = $clog2(BUF_W + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [AXIS_BW-1:0] s_axis_tdata,
  input  logic               s_axis_tlast,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [CFG_BW-1:0]  m_axis_tdata,
  output logic               m_axis_tlast,
  output logic [STAT_BW-1:0] stat_words,
  output logic [STAT_BW-1:0] stat_frames,
  output logic [CNT_BW-1:0]  residue_bits
);

  if (AXIS_BW <= CFG_BW) begin : g_width_check
    $error("cfg_axis_unpack: AXIS_BW must be greater than CFG_BW");
  end

  localparam logic [CNT_BW-1:0] CFG_CNT  = CNT_BW'(CFG_BW);
  localparam logic [CNT_BW-1:0] CFG2_CNT = CNT_BW'(2 * CFG_BW);
  localparam logic [CNT_BW-1:0] AXIS_CNT = CNT_BW'(AXIS_BW);
  localparam logic [STAT_BW-1:0] STAT_ONE = STAT_BW'(1);

  logic [BUF_W-1:0]   hold_buf_q, hold_buf_d;
  logic [CNT_BW-1:0]  cnt_q, cnt_d;
  logic               last_pend_q, last_pend_d;
  logic [STAT_BW-1:0] stat_words_q, stat_words_d;
  logic [STAT_BW-1:0] stat_frames_q, stat_frames_d;
  logic [CNT_BW-1:0]  residue_q, residue_d;

  logic push, pop;

  // Ready/valid come from registers only, so a push and a pop can never coincide:
  // input is accepted only below one word, output offered only at or above one word.
  assign s_axis_tready = (cnt_q < CFG_CNT) && !last_pend_q;
  assign m_axis_tvalid = (cnt_q >= CFG_CNT);
  assign m_axis_tdata  = hold_buf_q[CFG_BW-1:0];
  assign m_axis_tlast  = last_pend_q && (cnt_q < CFG2_CNT);

  assign push = s_axis_tvalid && s_axis_tready;
  assign pop  = m_axis_tvalid && m_axis_tready;

  assign stat_words   = stat_words_q;
  assign stat_frames  = stat_frames_q;
  assign residue_bits = residue_q;

  // NOTE: combinational next-state uses blocking '=' with every target defaulted first,
  // which keeps the block latch-free; only the register process below uses '<='.
  always_comb begin
    hold_buf_d    = hold_buf_q;
    cnt_d         = cnt_q;
    last_pend_d   = last_pend_q;
    stat_words_d  = stat_words_q;
    stat_frames_d = stat_frames_q;
    residue_d     = residue_q;

    if (push) begin
      hold_buf_d[cnt_q +: AXIS_BW] = s_axis_tdata;
      cnt_d                        = cnt_q + AXIS_CNT;
      last_pend_d                  = s_axis_tlast;
    end else if (pop) begin
      stat_words_d = (&stat_words_q) ? stat_words_q : stat_words_q + STAT_ONE;
      if (m_axis_tlast) begin
        // Whatever is left after the final word is padding; frames never share a word.
        residue_d     = cnt_q - CFG_CNT;
        hold_buf_d    = '0;
        cnt_d         = '0;
        last_pend_d   = 1'b0;
        stat_frames_d = (&stat_frames_q) ? stat_frames_q : stat_frames_q + STAT_ONE;
      end else begin
        hold_buf_d = hold_buf_q >> CFG_BW;
        cnt_d      = cnt_q - CFG_CNT;
      end
    end
  end

  // NOTE: the holding buffer is cleared on reset so an aborted frame leaves no stale
  // bits behind; the next frame starts from an all-zero buffer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hold_buf_q    <= '0;
      cnt_q         <= '0;
      last_pend_q   <= 1'b0;
      stat_words_q  <= '0;
      stat_frames_q <= '0;
      residue_q     <= '0;
    end else begin
      hold_buf_q    <= hold_buf_d;
      cnt_q         <= cnt_d;
      last_pend_q   <= last_pend_d;
      stat_words_q  <= stat_words_d;
      stat_frames_q <= stat_frames_d;
      residue_q     <= residue_d;
    end
  end

endmodule
